// File: rtl/axi_adapter_arbiter.sv
// axi_adapter_arbiter
// Round-robin arbiter that funnels NR_PORTS cache-side requesters into the
// single-outstanding AXI adapter and routes the adapter's response back to
// the port that owns the transaction in flight.
//
// Handshake summary: a requester holds req_i[p] and its request fields
// stable until it sees gnt_o[p] (one cycle, combinational from adp_gnt_i).
// The completion arrives later as a one-cycle valid_o[p] strobe, with
// rdata_o valid in that same cycle. The adapter side follows the same rule:
// adp_req_o stays high with stable fields until adp_gnt_i, and adp_valid_i
// marks a one-cycle response. Only one transaction is in flight at a time.
module axi_adapter_arbiter #(
    parameter int unsigned NR_PORTS     = 3,
    parameter int unsigned DATA_WIDTH   = 256,
    parameter int unsigned AXI_ID_WIDTH = 10
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    // requester side
    input  logic [NR_PORTS-1:0]                   req_i,
    input  logic [NR_PORTS-1:0]                   single_i,
    input  logic [NR_PORTS-1:0]                   we_i,
    input  logic [NR_PORTS-1:0][63:0]             addr_i,
    input  logic [NR_PORTS-1:0][DATA_WIDTH-1:0]   wdata_i,
    input  logic [NR_PORTS-1:0][DATA_WIDTH/8-1:0] be_i,
    input  logic [NR_PORTS-1:0][1:0]              size_i,
    output logic [NR_PORTS-1:0]                   gnt_o,
    output logic [NR_PORTS-1:0]                   valid_o,
    output logic [DATA_WIDTH-1:0]                 rdata_o,
    output logic [63:0]                           critical_word_o,
    output logic [NR_PORTS-1:0]                   critical_word_valid_o,
    // adapter request
    output logic                                  adp_req_o,
    output logic                                  adp_single_o,
    output logic                                  adp_we_o,
    output logic [63:0]                           adp_addr_o,
    output logic [DATA_WIDTH-1:0]                 adp_wdata_o,
    output logic [DATA_WIDTH/8-1:0]               adp_be_o,
    output logic [1:0]                            adp_size_o,
    output logic [AXI_ID_WIDTH-1:0]               adp_id_o,
    // adapter response
    input  logic                                  adp_gnt_i,
    input  logic                                  adp_valid_i,
    input  logic [DATA_WIDTH-1:0]                 adp_rdata_i,
    input  logic [AXI_ID_WIDTH-1:0]               adp_id_i,
    input  logic [63:0]                           adp_critical_word_i,
    input  logic                                  adp_critical_word_valid_i,
    // debug: current FSM state (0 = IDLE, 1 = REQ, 2 = WAIT_RESP)
    output logic [1:0]                            state_o
);

    localparam int unsigned PW = $clog2(NR_PORTS);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic                    single;
        logic                    we;
        logic [63:0]             addr;
        logic [DATA_WIDTH-1:0]   wdata;
        logic [DATA_WIDTH/8-1:0] be;
        logic [1:0]              size;
    } req_t;

    state_e        state_q, state_d;
    logic [PW-1:0] rr_q, rr_d;
    logic [PW-1:0] owner_q, owner_d;
    req_t          req_q, req_d;

    logic [PW-1:0] sel;
    logic          sel_valid;
    req_t          sel_req;
    req_t          fwd;

    // Only the low PW bits of the response ID are meaningful; the rest is
    // folded here so the full input is consumed.
    logic unused_id;
    assign unused_id = ^adp_id_i;

    // Port index arithmetic modulo NR_PORTS.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] a, input int unsigned b);
        int unsigned s;
        s = a + b;
        if (s >= NR_PORTS) s = s - NR_PORTS;
        return PW'(s);
    endfunction

    // Round-robin pick: first requesting port at or above rr_q, wrapping.
    always_comb begin
        sel       = '0;
        sel_valid = 1'b0;
        for (int i = 0; i < NR_PORTS; i++) begin
            if (!sel_valid && req_i[wrap_add(rr_q, i)]) begin
                sel_valid = 1'b1;
                sel       = wrap_add(rr_q, i);
            end
        end
    end

    // Gather the selected port's request fields.
    always_comb begin
        sel_req.single = single_i[sel];
        sel_req.we     = we_i[sel];
        sel_req.addr   = addr_i[sel];
        sel_req.wdata  = wdata_i[sel];
        sel_req.be     = be_i[sel];
        sel_req.size   = size_i[sel];
    end

    // Next-state and output decode; everything reads as idle while reset is held.
    always_comb begin
        state_d               = state_q;
        rr_d                  = rr_q;
        owner_d               = owner_q;
        req_d                 = req_q;
        fwd                   = '0;
        adp_req_o             = 1'b0;
        adp_id_o              = '0;
        gnt_o                 = '0;
        valid_o               = '0;
        rdata_o               = '0;
        critical_word_o       = '0;
        critical_word_valid_o = '0;

        if (rst_ni) begin
            unique case (state_q)
                IDLE: begin
                    if (sel_valid) begin
                        adp_req_o = 1'b1;
                        fwd       = sel_req;
                        adp_id_o  = AXI_ID_WIDTH'(sel);
                        owner_d   = sel;
                        req_d     = sel_req;
                        if (adp_gnt_i) begin
                            gnt_o[sel] = 1'b1;
                            rr_d       = wrap_add(sel, 1);
                            state_d    = WAIT_RESP;
                        end else begin
                            state_d = REQ;
                        end
                    end
                end
                REQ: begin
                    // Selection is locked: forward the registered request only.
                    adp_req_o = 1'b1;
                    fwd       = req_q;
                    adp_id_o  = AXI_ID_WIDTH'(owner_q);
                    if (adp_gnt_i) begin
                        gnt_o[owner_q] = 1'b1;
                        rr_d           = wrap_add(owner_q, 1);
                        state_d        = WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    critical_word_valid_o[owner_q] = adp_critical_word_valid_i;
                    if (adp_critical_word_valid_i) begin
                        critical_word_o = adp_critical_word_i;
                    end
                    if (adp_valid_i) begin
                        valid_o[owner_q] = 1'b1;
                        rdata_o          = adp_rdata_i;
                        state_d          = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign adp_single_o = fwd.single;
    assign adp_we_o     = fwd.we;
    assign adp_addr_o   = fwd.addr;
    assign adp_wdata_o  = fwd.wdata;
    assign adp_be_o     = fwd.be;
    assign adp_size_o   = fwd.size;
    assign state_o      = state_q;

    // State, pointer, owner and latched request registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rr_q    <= '0;
            owner_q <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            req_q   <= req_d;
        end
    end

    // The owner must hold its request until it is granted.
    owner_holds_req: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (state_q == REQ) |-> req_i[owner_q]
    );

    // The adapter's response must carry the owner's ID.
    resp_id_matches_owner: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (state_q == WAIT_RESP && adp_valid_i) |-> (adp_id_i[PW-1:0] == owner_q)
    );

    // At most one port is granted or completed per cycle.
    gnt_onehot: assert property (
        @(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_o) && $onehot0(valid_o)
    );

endmodule

// File: tb/tb_axi_adapter_arbiter.sv
// Directed bench for axi_adapter_arbiter (3 ports, 256-bit lines).
module tb_axi_adapter_arbiter;

  localparam int unsigned NP = 3;
  localparam int unsigned DW = 256;
  localparam int unsigned IW = 10;
  localparam int unsigned PW = 2;

  logic                    clk_i;
  logic                    rst_ni;
  logic [NP-1:0]           req_i;
  logic [NP-1:0]           single_i;
  logic [NP-1:0]           we_i;
  logic [NP-1:0][63:0]     addr_i;
  logic [NP-1:0][DW-1:0]   wdata_i;
  logic [NP-1:0][DW/8-1:0] be_i;
  logic [NP-1:0][1:0]      size_i;
  logic [NP-1:0]           gnt_o;
  logic [NP-1:0]           valid_o;
  logic [DW-1:0]           rdata_o;
  logic [63:0]             critical_word_o;
  logic [NP-1:0]           critical_word_valid_o;
  logic                    adp_req_o;
  logic                    adp_single_o;
  logic                    adp_we_o;
  logic [63:0]             adp_addr_o;
  logic [DW-1:0]           adp_wdata_o;
  logic [DW/8-1:0]         adp_be_o;
  logic [1:0]              adp_size_o;
  logic [IW-1:0]           adp_id_o;
  logic                    adp_gnt_i;
  logic                    adp_valid_i;
  logic [DW-1:0]           adp_rdata_i;
  logic [IW-1:0]           adp_id_i;
  logic [63:0]             adp_critical_word_i;
  logic                    adp_critical_word_valid_i;
  logic [1:0]              state_o;

  int checks   = 0;
  int failures = 0;

  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] e;
  logic [DW-1:0] exp_rdata;

  axi_adapter_arbiter #(
    .NR_PORTS(NP), .DATA_WIDTH(DW), .AXI_ID_WIDTH(IW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_i(req_i), .single_i(single_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .be_i(be_i), .size_i(size_i),
    .gnt_o(gnt_o), .valid_o(valid_o), .rdata_o(rdata_o),
    .critical_word_o(critical_word_o), .critical_word_valid_o(critical_word_valid_o),
    .adp_req_o(adp_req_o), .adp_single_o(adp_single_o), .adp_we_o(adp_we_o),
    .adp_addr_o(adp_addr_o), .adp_wdata_o(adp_wdata_o), .adp_be_o(adp_be_o),
    .adp_size_o(adp_size_o), .adp_id_o(adp_id_o),
    .adp_gnt_i(adp_gnt_i), .adp_valid_i(adp_valid_i), .adp_rdata_i(adp_rdata_i),
    .adp_id_i(adp_id_i), .adp_critical_word_i(adp_critical_word_i),
    .adp_critical_word_valid_i(adp_critical_word_valid_i),
    .state_o(state_o)
  );

  // clock: posedges at 5, 15, 25, ...
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic fail(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    failures++;
    $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive_port(input int p, input logic single, input logic we,
                            input logic [63:0] addr, input logic [1:0] size);
    req_i[p]    = 1'b1;
    single_i[p] = single;
    we_i[p]     = we;
    addr_i[p]   = addr;
    size_i[p]   = size;
  endtask

  initial begin
    rst_ni                    = 1'b0;
    req_i                     = '0;
    single_i                  = '0;
    we_i                      = '0;
    addr_i                    = '0;
    wdata_i                   = '0;
    be_i                      = '0;
    size_i                    = '0;
    adp_gnt_i                 = 1'b0;
    adp_valid_i               = 1'b0;
    adp_rdata_i               = '0;
    adp_id_i                  = '0;
    adp_critical_word_i       = '0;
    adp_critical_word_valid_i = 1'b0;

    // ---------------- reset state (all ports already requesting)
    for (int p = 0; p < NP; p++) drive_port(p, 1'b1, 1'b0, 64'h100 * (p + 1), 2'd3);
    adp_gnt_i = 1'b1;
    #3;
    checks++; if (state_o !== 2'd0) fail("rst_state", state_o, 2'd0);
    checks++; if (gnt_o !== 3'b000) fail("rst_gnt", gnt_o, 3'b000);
    checks++; if (valid_o !== 3'b000) fail("rst_valid", valid_o, 3'b000);
    checks++; if (critical_word_valid_o !== 3'b000) fail("rst_cwv", critical_word_valid_o, 3'b000);
    checks++; if (adp_req_o !== 1'b0) fail("rst_adp_req", adp_req_o, 1'b0);
    checks++; if (adp_addr_o !== 64'h0) fail("rst_adp_addr", adp_addr_o, 64'h0);
    checks++; if (rdata_o !== {DW{1'b0}}) fail("rst_rdata", rdata_o, {DW{1'b0}});
    adp_gnt_i = 1'b0;
    #9;
    rst_ni = 1'b1;
    cyc();

    // ---------------- round-robin fairness: all ports, immediate grant, response after 2 cycles
    for (int t = 0; t < 6; t++) exp_q.push_back(PW'(t % 3));
    for (int t = 0; t < 6; t++) begin
      e = exp_q.pop_front();
      adp_gnt_i = 1'b1;
      #1;
      checks++; if (gnt_o !== (3'b001 << e)) fail("rr_gnt", gnt_o, 3'b001 << e);
      checks++; if (adp_id_o !== 10'(e)) fail("rr_id", adp_id_o, 10'(e));
      checks++; if (adp_addr_o !== 64'h100 * (e + 1)) fail("rr_addr", adp_addr_o, 64'h100 * (e + 1));
      cyc();
      adp_gnt_i = 1'b0;
      #1;
      checks++; if (adp_req_o !== 1'b0) fail("rr_wait_req", adp_req_o, 1'b0);
      checks++; if (valid_o !== 3'b000) fail("rr_wait_valid", valid_o, 3'b000);
      cyc();
      adp_valid_i     = 1'b1;
      adp_id_i        = 10'(e);
      exp_rdata       = {DW{1'b0}};
      exp_rdata[31:0] = 32'hC0DE_0000 + t;
      adp_rdata_i     = exp_rdata;
      #1;
      checks++; if (valid_o !== (3'b001 << e)) fail("rr_valid", valid_o, 3'b001 << e);
      checks++; if (rdata_o !== exp_rdata) fail("rr_rdata", rdata_o, exp_rdata);
      cyc();
      adp_valid_i = 1'b0;
    end
    checks++; if (exp_q.size() != 0) fail("rr_queue_drained", exp_q.size(), 0);
    req_i = '0;

    // ---------------- single read on port 1, grant same cycle, valid 4 cycles later
    drive_port(1, 1'b1, 1'b0, 64'h8000_0040, 2'd2);
    adp_gnt_i = 1'b1;
    #1;
    checks++; if (gnt_o !== 3'b010) fail("sr_gnt", gnt_o, 3'b010);
    checks++; if (adp_id_o !== 10'd1) fail("sr_id", adp_id_o, 10'd1);
    checks++; if (adp_addr_o !== 64'h8000_0040) fail("sr_addr", adp_addr_o, 64'h8000_0040);
    checks++; if (adp_single_o !== 1'b1) fail("sr_single", adp_single_o, 1'b1);
    checks++; if (adp_we_o !== 1'b0) fail("sr_we", adp_we_o, 1'b0);
    checks++; if (adp_size_o !== 2'd2) fail("sr_size", adp_size_o, 2'd2);
    cyc();
    req_i     = '0;
    adp_gnt_i = 1'b0;
    #1;
    checks++; if (state_o !== 2'd2) fail("sr_state_wait", state_o, 2'd2);
    checks++; if (adp_req_o !== 1'b0) fail("sr_adp_req_low", adp_req_o, 1'b0);
    for (int k = 0; k < 2; k++) begin
      cyc();
      checks++; if (valid_o !== 3'b000) fail("sr_no_valid", valid_o, 3'b000);
    end
    cyc();
    adp_valid_i       = 1'b1;
    adp_id_i          = 10'd1;
    adp_rdata_i       = {DW{1'b0}};
    adp_rdata_i[31:0] = 32'hDEAD_BEEF;
    #1;
    checks++; if (valid_o !== 3'b010) fail("sr_valid", valid_o, 3'b010);
    checks++; if (rdata_o[31:0] !== 32'hDEAD_BEEF) fail("sr_rdata_w0", rdata_o[31:0], 32'hDEAD_BEEF);
    cyc();
    adp_valid_i = 1'b0;

    // ---------------- locked selection: port 2 waits 5 cycles for grant, port 0 arrives in cycle 2
    drive_port(2, 1'b0, 1'b0, 64'h2000, 2'd3);
    #1;
    checks++; if (adp_req_o !== 1'b1) fail("lk_c1_req", adp_req_o, 1'b1);
    checks++; if (adp_addr_o !== 64'h2000) fail("lk_c1_addr", adp_addr_o, 64'h2000);
    checks++; if (gnt_o !== 3'b000) fail("lk_c1_gnt", gnt_o, 3'b000);
    cyc();
    drive_port(0, 1'b0, 1'b0, 64'h3000, 2'd3);
    #1;
    checks++; if (state_o !== 2'd1) fail("lk_c2_state", state_o, 2'd1);
    checks++; if (adp_addr_o !== 64'h2000) fail("lk_c2_addr", adp_addr_o, 64'h2000);
    checks++; if (adp_id_o !== 10'd2) fail("lk_c2_id", adp_id_o, 10'd2);
    checks++; if (gnt_o !== 3'b000) fail("lk_c2_gnt", gnt_o, 3'b000);
    cyc();
    addr_i[2] = 64'hFFFF;
    #1;
    checks++; if (adp_addr_o !== 64'h2000) fail("lk_c3_addr_latched", adp_addr_o, 64'h2000);
    cyc();
    checks++; if (adp_addr_o !== 64'h2000) fail("lk_c4_addr", adp_addr_o, 64'h2000);
    cyc();
    adp_gnt_i = 1'b1;
    #1;
    checks++; if (gnt_o !== 3'b100) fail("lk_c5_gnt", gnt_o, 3'b100);
    checks++; if (adp_addr_o !== 64'h2000) fail("lk_c5_addr", adp_addr_o, 64'h2000);
    cyc();
    req_i[2]  = 1'b0;
    adp_gnt_i = 1'b0;
    #1;
    checks++; if (gnt_o !== 3'b000) fail("lk_wait_gnt", gnt_o, 3'b000);
    checks++; if (adp_req_o !== 1'b0) fail("lk_wait_req", adp_req_o, 1'b0);
    cyc();
    adp_valid_i = 1'b1;
    adp_id_i    = 10'd2;
    #1;
    checks++; if (valid_o !== 3'b100) fail("lk_p2_valid", valid_o, 3'b100);
    checks++; if (gnt_o !== 3'b000) fail("lk_p0_not_yet", gnt_o, 3'b000);
    cyc();
    adp_valid_i = 1'b0;
    adp_gnt_i   = 1'b1;
    #1;
    checks++; if (gnt_o !== 3'b001) fail("lk_p0_gnt", gnt_o, 3'b001);
    checks++; if (adp_addr_o !== 64'h3000) fail("lk_p0_addr", adp_addr_o, 64'h3000);
    cyc();
    req_i     = '0;
    adp_gnt_i = 1'b0;
    cyc();
    adp_valid_i = 1'b1;
    adp_id_i    = 10'd0;
    #1;
    checks++; if (valid_o !== 3'b001) fail("lk_p0_valid", valid_o, 3'b001);
    cyc();
    adp_valid_i = 1'b0;

    // ---------------- critical word routing to port 0
    drive_port(0, 1'b0, 1'b0, 64'h1010, 2'd3);
    adp_gnt_i = 1'b1;
    #1;
    checks++; if (gnt_o !== 3'b001) fail("cw_gnt", gnt_o, 3'b001);
    checks++; if (adp_single_o !== 1'b0) fail("cw_single", adp_single_o, 1'b0);
    checks++; if (adp_addr_o !== 64'h1010) fail("cw_addr", adp_addr_o, 64'h1010);
    cyc();
    req_i                     = '0;
    adp_gnt_i                 = 1'b0;
    adp_critical_word_valid_i = 1'b1;
    adp_critical_word_i       = 64'h55AA;
    #1;
    checks++; if (critical_word_valid_o !== 3'b001) fail("cw_valid_strobe", critical_word_valid_o, 3'b001);
    checks++; if (critical_word_o !== 64'h55AA) fail("cw_word", critical_word_o, 64'h55AA);
    checks++; if (valid_o !== 3'b000) fail("cw_no_valid_yet", valid_o, 3'b000);
    cyc();
    adp_critical_word_valid_i = 1'b0;
    #1;
    checks++; if (critical_word_valid_o !== 3'b000) fail("cw_strobe_drop", critical_word_valid_o, 3'b000);
    cyc();
    adp_valid_i = 1'b1;
    adp_id_i    = 10'd0;
    #1;
    checks++; if (valid_o !== 3'b001) fail("cw_valid", valid_o, 3'b001);
    cyc();
    adp_valid_i = 1'b0;

    // ---------------- write completion on port 2
    drive_port(2, 1'b0, 1'b1, 64'h4000, 2'd3);
    wdata_i[2] = {8{32'h1234_5678}};
    be_i[2]    = {(DW/8){1'b1}};
    adp_gnt_i  = 1'b1;
    #1;
    checks++; if (gnt_o !== 3'b100) fail("wr_gnt", gnt_o, 3'b100);
    checks++; if (adp_we_o !== 1'b1) fail("wr_we", adp_we_o, 1'b1);
    checks++; if (adp_be_o !== 32'hFFFF_FFFF) fail("wr_be", adp_be_o, 32'hFFFF_FFFF);
    checks++; if (adp_wdata_o !== {8{32'h1234_5678}}) fail("wr_wdata", adp_wdata_o, {8{32'h1234_5678}});
    cyc();
    req_i     = '0;
    adp_gnt_i = 1'b0;
    #1;
    checks++; if (critical_word_valid_o !== 3'b000) fail("wr_no_cwv", critical_word_valid_o, 3'b000);
    cyc();
    adp_valid_i = 1'b1;
    adp_id_i    = 10'd2;
    #1;
    checks++; if (valid_o !== 3'b100) fail("wr_valid", valid_o, 3'b100);
    checks++; if (critical_word_valid_o !== 3'b000) fail("wr_no_cwv_done", critical_word_valid_o, 3'b000);
    cyc();
    adp_valid_i = 1'b0;

    // ---------------- reset in WAIT_RESP, then port 0 wins first
    drive_port(1, 1'b1, 1'b0, 64'h5000, 2'd3);
    adp_gnt_i = 1'b1;
    #1;
    checks++; if (gnt_o !== 3'b010) fail("mr_gnt", gnt_o, 3'b010);
    cyc();
    req_i     = '0;
    adp_gnt_i = 1'b0;
    #1;
    checks++; if (state_o !== 2'd2) fail("mr_state_wait", state_o, 2'd2);
    rst_ni                    = 1'b0;
    adp_valid_i               = 1'b1;
    adp_critical_word_valid_i = 1'b1;
    adp_id_i                  = 10'd1;
    adp_gnt_i                 = 1'b1;
    req_i                     = 3'b111;
    #1;
    checks++; if (state_o !== 2'd0) fail("mr_state", state_o, 2'd0);
    checks++; if (valid_o !== 3'b000) fail("mr_valid", valid_o, 3'b000);
    checks++; if (critical_word_valid_o !== 3'b000) fail("mr_cwv", critical_word_valid_o, 3'b000);
    checks++; if (gnt_o !== 3'b000) fail("mr_gnt_off", gnt_o, 3'b000);
    checks++; if (adp_req_o !== 1'b0) fail("mr_adp_req", adp_req_o, 1'b0);
    checks++; if (rdata_o !== {DW{1'b0}}) fail("mr_rdata", rdata_o, {DW{1'b0}});
    rst_ni                    = 1'b1;
    adp_valid_i               = 1'b0;
    adp_critical_word_valid_i = 1'b0;
    #1;
    checks++; if (gnt_o !== 3'b001) fail("mr_first_gnt", gnt_o, 3'b001);
    checks++; if (adp_id_o !== 10'd0) fail("mr_first_id", adp_id_o, 10'd0);
    cyc();
    req_i     = '0;
    adp_gnt_i = 1'b0;
    cyc();
    adp_valid_i = 1'b1;
    adp_id_i    = 10'd0;
    #1;
    checks++; if (valid_o !== 3'b001) fail("mr_first_valid", valid_o, 3'b001);
    cyc();
    adp_valid_i = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // overall time bound
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench time limit reached");
  end

endmodule
